// File: rtl/ctrl_multicycle_if.sv
// Control-unit to datapath bundle: IR/zero flag in, per-state datapath strobes out.
interface ctrl_multicycle_if #(
    parameter int unsigned ALU_CTL_W = 4
);
    logic [31:0]          instruction;
    logic                 zero;
    logic                 pc_write;
    logic [1:0]           npc_sel;
    logic                 ir_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 iord;
    logic [1:0]           reg_dst;
    logic                 reg_write;
    logic [1:0]           mem_to_reg;
    logic                 alu_src;
    logic                 ext_op;
    logic [ALU_CTL_W-1:0] alu_ctl;
    logic [2:0]           state;
    logic                 illegal;

    modport master (
        input  instruction, zero,
        output pc_write, npc_sel, ir_write, mem_read, mem_write, iord,
               reg_dst, reg_write, mem_to_reg, alu_src, ext_op, alu_ctl,
               state, illegal
    );

    modport slave (
        output instruction, zero,
        input  pc_write, npc_sel, ir_write, mem_read, mem_write, iord,
               reg_dst, reg_write, mem_to_reg, alu_src, ext_op, alu_ctl,
               state, illegal
    );
endinterface

// File: rtl/ctrl_multicycle.sv
// Multi-cycle MIPS-lite control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// parametrised memory wait states; strobes are decoded from state, wcnt and IR.
module ctrl_multicycle #(
    parameter int unsigned MEM_WAIT  = 0,
    parameter int unsigned ALU_CTL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    ctrl_multicycle_if.master  bus
);
    localparam int unsigned WCNT_W = 4;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_WAIT);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_CMP = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_LUI = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic [5:0] opcode, funct;
    logic is_rtype, is_addu, is_subu, is_slt, is_jr;
    logic is_j, is_jal, is_beq, is_addi, is_ori, is_lui, is_lw, is_sw;
    logic is_legal, wait_done;

    logic                 pc_write_c, ir_write_c, mem_read_c, mem_write_c;
    logic                 iord_c, reg_write_c, alu_src_c, ext_op_c, illegal_c;
    logic [1:0]           npc_sel_c, reg_dst_c, mem_to_reg_c;
    logic [ALU_CTL_W-1:0] alu_ctl_c;

    // Instruction class decode; the IR is stable from DECODE onwards.
    assign opcode   = bus.instruction[31:26];
    assign funct    = bus.instruction[5:0];
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_addu  = is_rtype && (funct == FN_ADDU);
    assign is_subu  = is_rtype && (funct == FN_SUBU);
    assign is_slt   = is_rtype && (funct == FN_SLT);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_j     = (opcode == OP_J);
    assign is_jal   = (opcode == OP_JAL);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_ori   = (opcode == OP_ORI);
    assign is_lui   = (opcode == OP_LUI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_legal = is_addu | is_subu | is_slt | is_jr | is_j | is_jal |
                      is_beq | is_addi | is_ori | is_lui | is_lw | is_sw;

    assign wait_done = (wcnt_q == WCNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next state and per-state strobes; everything is forced low during reset.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        pc_write_c   = 1'b0;
        npc_sel_c    = 2'd0;
        ir_write_c   = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        iord_c       = 1'b0;
        reg_dst_c    = 2'd0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 2'd0;
        alu_src_c    = 1'b0;
        ext_op_c     = 1'b0;
        alu_ctl_c    = '0;
        illegal_c    = 1'b0;

        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read_c = 1'b1;
                    if (wait_done) begin
                        ir_write_c = 1'b1;
                        pc_write_c = 1'b1;
                        wcnt_d     = '0;
                        state_d    = S_DECODE;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (is_j) begin
                        pc_write_c = 1'b1;
                        npc_sel_c  = 2'd2;
                        state_d    = S_FETCH;
                    end else if (is_jr) begin
                        pc_write_c = 1'b1;
                        npc_sel_c  = 2'd3;
                        state_d    = S_FETCH;
                    end else if (is_jal) begin
                        state_d = S_WB;
                    end else if (!is_legal) begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    wcnt_d  = '0;
                    state_d = (is_lw || is_sw) ? S_MEM : S_WB;
                    if (is_subu) begin
                        alu_ctl_c = ALU_CTL_W'(ALU_SUB);
                    end else if (is_slt) begin
                        alu_ctl_c = ALU_CTL_W'(ALU_SLT);
                    end else if (is_ori) begin
                        alu_src_c = 1'b1;
                        alu_ctl_c = ALU_CTL_W'(ALU_OR);
                    end else if (is_lui) begin
                        alu_src_c = 1'b1;
                        alu_ctl_c = ALU_CTL_W'(ALU_LUI);
                    end else if (is_addi || is_lw || is_sw) begin
                        alu_src_c = 1'b1;
                        ext_op_c  = 1'b1;
                        alu_ctl_c = ALU_CTL_W'(ALU_ADD);
                    end else if (is_beq) begin
                        alu_ctl_c  = ALU_CTL_W'(ALU_CMP);
                        pc_write_c = bus.zero;
                        npc_sel_c  = 2'd1;
                        state_d    = S_FETCH;
                    end else begin
                        alu_ctl_c = ALU_CTL_W'(ALU_ADD);
                    end
                end
                S_MEM: begin
                    iord_c     = 1'b1;
                    mem_read_c = is_lw;
                    if (wait_done) begin
                        mem_write_c = is_sw;
                        wcnt_d      = '0;
                        state_d     = is_lw ? S_WB : S_FETCH;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
                S_WB: begin
                    reg_write_c = 1'b1;
                    state_d     = S_FETCH;
                    if (is_rtype) begin
                        reg_dst_c = 2'd1;
                    end else if (is_lw) begin
                        mem_to_reg_c = 2'd1;
                    end else if (is_jal) begin
                        reg_dst_c    = 2'd2;
                        mem_to_reg_c = 2'd2;
                        pc_write_c   = 1'b1;
                        npc_sel_c    = 2'd2;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                    wcnt_d  = '0;
                end
            endcase
        end
    end

    assign bus.pc_write   = pc_write_c;
    assign bus.npc_sel    = npc_sel_c;
    assign bus.ir_write   = ir_write_c;
    assign bus.mem_read   = mem_read_c;
    assign bus.mem_write  = mem_write_c;
    assign bus.iord       = iord_c;
    assign bus.reg_dst    = reg_dst_c;
    assign bus.reg_write  = reg_write_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.alu_src    = alu_src_c;
    assign bus.ext_op     = ext_op_c;
    assign bus.alu_ctl    = alu_ctl_c;
    assign bus.state      = rst ? S_FETCH : state_q;
    assign bus.illegal    = illegal_c;
endmodule

// File: tb/tb_ctrl_multicycle.sv
// Bench for ctrl_multicycle: two instances (MEM_WAIT 0 and 2) checked cycle by
// cycle against per-instruction expected output traces.
module tb_ctrl_multicycle;
    typedef struct packed {
        logic [2:0] state;
        logic       pc_write;
        logic [1:0] npc_sel;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       alu_src;
        logic       ext_op;
        logic [3:0] alu_ctl;
        logic       illegal;
    } ctl_t;

    localparam int K_ADDU = 0, K_SUBU = 1, K_SLT = 2, K_JR = 3, K_J = 4, K_JAL = 5,
                   K_BEQ = 6, K_ADDI = 7, K_ORI = 8, K_LUI = 9, K_LW = 10, K_SW = 11,
                   K_ILL = 12;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst2 = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    ctl_t exp_q[$];
    ctl_t obs0, obs2;

    always #5 clk = ~clk;

    ctrl_multicycle_if #(.ALU_CTL_W(4)) if0 ();
    ctrl_multicycle_if #(.ALU_CTL_W(4)) if2 ();

    ctrl_multicycle #(.MEM_WAIT(0), .ALU_CTL_W(4)) dut0 (.clk(clk), .rst(rst0), .bus(if0.master));
    ctrl_multicycle #(.MEM_WAIT(2), .ALU_CTL_W(4)) dut2 (.clk(clk), .rst(rst2), .bus(if2.master));

    assign obs0 = {if0.state, if0.pc_write, if0.npc_sel, if0.ir_write, if0.mem_read,
                   if0.mem_write, if0.iord, if0.reg_dst, if0.reg_write, if0.mem_to_reg,
                   if0.alu_src, if0.ext_op, if0.alu_ctl, if0.illegal};
    assign obs2 = {if2.state, if2.pc_write, if2.npc_sel, if2.ir_write, if2.mem_read,
                   if2.mem_write, if2.iord, if2.reg_dst, if2.reg_write, if2.mem_to_reg,
                   if2.alu_src, if2.ext_op, if2.alu_ctl, if2.illegal};

    task automatic check(input string tag, input ctl_t got, input ctl_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (st=%0d/%0d)", tag, got, want,
                     got.state, want.state);
        end
    endtask

    function automatic int classify(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        case (op)
            6'h00: case (fn)
                       6'h21: return K_ADDU;
                       6'h23: return K_SUBU;
                       6'h2A: return K_SLT;
                       6'h08: return K_JR;
                       default: return K_ILL;
                   endcase
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h04: return K_BEQ;
            6'h08: return K_ADDI;
            6'h0D: return K_ORI;
            6'h0F: return K_LUI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            default: return K_ILL;
        endcase
    endfunction

    // Expected per-cycle outputs for one instruction from FETCH back to FETCH.
    task automatic gen_trace(input logic [31:0] ins, input logic z, input int w);
        ctl_t e;
        int   k;
        exp_q.delete();
        for (int c = 0; c <= w; c++) begin
            e = '0;
            e.mem_read = 1'b1;
            if (c == w) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
            end
            exp_q.push_back(e);
        end
        k = classify(ins);
        e = '0;
        e.state = 3'd1;
        if (k == K_J)   begin e.pc_write = 1'b1; e.npc_sel = 2'd2; end
        if (k == K_JR)  begin e.pc_write = 1'b1; e.npc_sel = 2'd3; end
        if (k == K_ILL) e.illegal = 1'b1;
        exp_q.push_back(e);
        if (k == K_J || k == K_JR || k == K_ILL) return;
        if (k != K_JAL) begin
            e = '0;
            e.state = 3'd2;
            case (k)
                K_SUBU: e.alu_ctl = 4'd1;
                K_SLT:  e.alu_ctl = 4'd5;
                K_ORI:  begin e.alu_src = 1'b1; e.alu_ctl = 4'd3; end
                K_LUI:  begin e.alu_src = 1'b1; e.alu_ctl = 4'd6; end
                K_ADDI, K_LW, K_SW: begin e.alu_src = 1'b1; e.ext_op = 1'b1; end
                K_BEQ:  begin e.alu_ctl = 4'd4; e.pc_write = z; e.npc_sel = 2'd1; end
                default: e.alu_ctl = 4'd0;
            endcase
            exp_q.push_back(e);
            if (k == K_BEQ) return;
        end
        if (k == K_LW || k == K_SW) begin
            for (int c = 0; c <= w; c++) begin
                e = '0;
                e.state     = 3'd3;
                e.iord      = 1'b1;
                e.mem_read  = (k == K_LW);
                e.mem_write = (k == K_SW) && (c == w);
                exp_q.push_back(e);
            end
            if (k == K_SW) return;
        end
        e = '0;
        e.state     = 3'd4;
        e.reg_write = 1'b1;
        if (k == K_ADDU || k == K_SUBU || k == K_SLT) e.reg_dst = 2'd1;
        if (k == K_LW) e.mem_to_reg = 2'd1;
        if (k == K_JAL) begin
            e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; e.pc_write = 1'b1; e.npc_sel = 2'd2;
        end
        exp_q.push_back(e);
    endtask

    // Entered and left at posedge+1; limit < 0 runs the whole instruction.
    task automatic run_instr(input int w, input logic [31:0] ins, input logic z,
                             input int limit, input string tag);
        int n;
        gen_trace(ins, z, w);
        n = (limit >= 0 && limit < exp_q.size()) ? limit : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if0.instruction = ins; if0.zero = z;
            if2.instruction = ins; if2.zero = z;
            #1;
            check($sformatf("%s[%08h] cyc%0d", tag, ins, i), (w == 2) ? obs2 : obs0, exp_q[i]);
            @(posedge clk);
            #1;
        end
    endtask

    // Both instances held in reset; the selected one is checked and released.
    task automatic hold_reset(input int w, input int cycles, input string tag);
        rst0 = 1'b1;
        rst2 = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            #1;
            check($sformatf("%s rst%0d", tag, i), (w == 2) ? obs2 : obs0, ctl_t'(0));
            @(posedge clk);
            #1;
        end
        if (w == 2) rst2 = 1'b0;
        else        rst0 = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  ops[9];
        logic [5:0]  fns[4];
        int          sel;
        ops = '{6'h02, 6'h03, 6'h04, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h00};
        fns = '{6'h21, 6'h23, 6'h2A, 6'h08};
        r   = $urandom;
        sel = $urandom_range(0, 14);
        if (sel < 9) begin
            r[31:26] = ops[sel];
            if (sel == 8) r[5:0] = fns[$urandom_range(0, 3)];
        end else if (sel < 12) begin
            r[31:26] = 6'h00;
            r[5:0]   = fns[$urandom_range(0, 3)];
        end else if (sel < 14) begin
            for (int t = 0; t < 64 && classify(r) != K_ILL; t++) r[31:26] = 6'($urandom);
            if (classify(r) != K_ILL) r[31:26] = 6'h3F;
        end else begin
            r[31:26] = 6'h00;
            for (int t = 0; t < 64 && classify(r) != K_ILL; t++) r[5:0] = 6'($urandom);
            if (classify(r) != K_ILL) r[5:0] = 6'h3F;
        end
        return r;
    endfunction

    initial begin
        if0.instruction = '0; if0.zero = 1'b0;
        if2.instruction = '0; if2.zero = 1'b0;
        @(posedge clk);
        #1;
        hold_reset(0, 3, "reset0");
        run_instr(0, 32'h00221821, 1'b0, -1, "addu");
        run_instr(0, 32'h00A62023, 1'b0, -1, "subu");
        run_instr(0, 32'h0022182A, 1'b0, -1, "slt");
        run_instr(0, 32'h10220003, 1'b1, -1, "beq_t");
        run_instr(0, 32'h10220003, 1'b0, -1, "beq_nt");
        run_instr(0, 32'h0C000010, 1'b0, -1, "jal");
        run_instr(0, 32'hFC000000, 1'b0, -1, "ill_op");
        run_instr(0, 32'h0022183F, 1'b0, -1, "ill_fn");
        run_instr(0, 32'h08000040, 1'b0, -1, "j");
        run_instr(0, 32'h03E00008, 1'b0, -1, "jr");
        run_instr(0, 32'h2022FFFF, 1'b0, -1, "addi");
        run_instr(0, 32'h3422F0F0, 1'b0, -1, "ori");
        run_instr(0, 32'h3C021234, 1'b0, -1, "lui");
        run_instr(0, 32'h8C050004, 1'b0, -1, "lw0");
        run_instr(0, 32'hAC050004, 1'b0, -1, "sw0");

        hold_reset(2, 2, "reset2");
        run_instr(2, 32'h8C050004, 1'b0, -1, "lw2");
        run_instr(2, 32'hAC050004, 1'b0, -1, "sw2");
        run_instr(2, 32'h8C050004, 1'b0, 6, "lw_abort");
        hold_reset(2, 3, "midmem");
        run_instr(2, 32'h00221821, 1'b0, -1, "after_rst");
        run_instr(2, 32'h0C000010, 1'b0, -1, "jal2");
        run_instr(2, 32'h10220003, 1'b1, -1, "beq2");
        for (int i = 0; i < 40; i++)
            run_instr(2, rand_instr(), 1'($urandom), -1, "rnd2");

        hold_reset(0, 1, "reset0b");
        for (int i = 0; i < 40; i++)
            run_instr(0, rand_instr(), 1'($urandom), -1, "rnd0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
